// File: rtl/bcd_counter_ndigit.sv
// N-digit packed-BCD up/down counter with clear, validated parallel load and
// selectable wrap/saturate at the limits; one nibble per digit, digit 0 lowest.
module bcd_counter_ndigit #(
    parameter int unsigned DIGITS   = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  grst,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  cout,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                load_err_q, load_err_d;

    logic [DIGITS-1:0]   carry_in;   // all lower digits are 9
    logic [DIGITS-1:0]   borrow_in;  // all lower digits are 0
    logic                at_max, at_min, terminal;

    logic [4*DIGITS-1:0] load_fixed;
    logic                load_bad;

    // Ripple chain across digits; this is the critical path at DIGITS=8.
    always_comb begin
        logic nine_run;
        logic zero_run;
        nine_run = 1'b1;
        zero_run = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            carry_in[i]  = nine_run;
            borrow_in[i] = zero_run;
            nine_run     = nine_run & (count_q[4*i +: 4] == 4'd9);
            zero_run     = zero_run & (count_q[4*i +: 4] == 4'd0);
        end
        at_max = nine_run;
        at_min = zero_run;
    end

    assign terminal = up ? at_max : at_min;
    assign cout     = enable & ~clr & ~load & terminal;

    // Non-BCD nibbles are clamped to 9 so the digits never leave 0-9.
    always_comb begin
        load_fixed = '0;
        load_bad   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_fixed[4*i +: 4] = 4'd9;
                load_bad             = 1'b1;
            end else begin
                load_fixed[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d    = load_fixed;
            load_err_d = load_bad;
        end else if (enable && !(SATURATE && terminal)) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (up && carry_in[i]) begin
                    count_d[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0
                                                                     : count_q[4*i +: 4] + 4'd1;
                end else if (!up && borrow_in[i]) begin
                    count_d[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? 4'd9
                                                                     : count_q[4*i +: 4] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge grst) begin
        if (!grst) begin
            count_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Self-checking bench: a wrapping and a saturating 4-digit instance share stimulus and
// are compared against an integer reference model through a scoreboard queue.
module tb_bcd_counter_ndigit;

    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;

    logic        clk = 1'b0;
    logic        grst;
    logic        enable, up, clr, load;
    logic [15:0] load_val;
    logic [15:0] count_w, count_s;
    logic        cout_w, cout_s, err_w, err_s;

    bcd_counter_ndigit #(.DIGITS(DIGITS), .SATURATE(1'b0)) dut_w (
        .clk(clk), .grst(grst), .enable(enable), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(count_w), .cout(cout_w), .load_err(err_w)
    );

    bcd_counter_ndigit #(.DIGITS(DIGITS), .SATURATE(1'b1)) dut_s (
        .clk(clk), .grst(grst), .enable(enable), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(count_s), .cout(cout_s), .load_err(err_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        up;
        logic        clr;
        logic        ld;
        logic [15:0] lv;
        logic [15:0] exp_cnt;
        logic        exp_err;
        logic        exp_cout;
    } vec_t;

    typedef struct {
        logic [15:0] cw;
        logic        ew;
        logic [15:0] cs;
        logic        es;
    } exp_t;

    exp_t sb[$];
    vec_t tab[$];

    int n_checks = 0;
    int n_fail   = 0;
    int mw = 0, ms = 0;
    int cout_hits = 0;
    logic last_cout_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] b);
        int v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] clamp_bcd(input logic [15:0] b);
        logic [15:0] r = b;
        for (int i = 0; i < DIGITS; i++) if (r[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    function automatic int next_val(input int m, input bit sat, input vec_t v);
        if (v.clr) return 0;
        if (v.ld) return bcd2int(clamp_bcd(v.lv));
        if (!v.en) return m;
        if (v.up) return (m == MAXV) ? (sat ? MAXV : 0) : m + 1;
        return (m == 0) ? (sat ? 0 : MAXV) : m - 1;
    endfunction

    function automatic logic next_err(input vec_t v);
        return !v.clr && v.ld && (clamp_bcd(v.lv) != v.lv);
    endfunction

    function automatic vec_t mk(input logic en, input logic u, input logic c, input logic ld,
                                input logic [15:0] lv, input logic [15:0] cnt,
                                input logic err, input logic co);
        vec_t v;
        v.en = en; v.up = u; v.clr = c; v.ld = ld; v.lv = lv;
        v.exp_cnt = cnt; v.exp_err = err; v.exp_cout = co;
        return v;
    endfunction

    task automatic apply(input vec_t v, input bit use_tab);
        exp_t e, got;
        logic exp_cw, exp_cs, ne;
        @(negedge clk);
        enable = v.en; up = v.up; clr = v.clr; load = v.ld; load_val = v.lv;
        #1;
        exp_cw = v.en & ~v.clr & ~v.ld & (v.up ? (mw == MAXV) : (mw == 0));
        exp_cs = v.en & ~v.clr & ~v.ld & (v.up ? (ms == MAXV) : (ms == 0));
        if (use_tab) check("tab_cout", 32'(cout_w), 32'(v.exp_cout));
        check("cout_wrap", 32'(cout_w), 32'(exp_cw));
        check("cout_sat", 32'(cout_s), 32'(exp_cs));
        last_cout_w = cout_w;
        ne = next_err(v);
        mw = next_val(mw, 1'b0, v);
        ms = next_val(ms, 1'b1, v);
        e.cw = use_tab ? v.exp_cnt : int2bcd(mw);
        e.ew = use_tab ? v.exp_err : ne;
        e.cs = int2bcd(ms);
        e.es = ne;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("count_wrap", 32'(count_w), 32'(got.cw));
        check("err_wrap", 32'(err_w), 32'(got.ew));
        check("count_sat", 32'(count_s), 32'(got.cs));
        check("err_sat", 32'(err_s), 32'(got.es));
    endtask

    initial begin
        // en, up, clr, load, load_val, expected count, load_err, cout (wrapping instance)
        tab.push_back(mk(0, 0, 0, 1, 16'h12A4, 16'h1294, 1, 0));
        tab.push_back(mk(1, 1, 0, 0, 16'h0000, 16'h1295, 0, 0));
        tab.push_back(mk(0, 0, 0, 1, 16'h5678, 16'h5678, 0, 0));
        tab.push_back(mk(0, 0, 0, 1, 16'h0042, 16'h0042, 0, 0));
        tab.push_back(mk(1, 1, 1, 1, 16'h7777, 16'h0000, 0, 0));
        tab.push_back(mk(1, 1, 0, 1, 16'h7777, 16'h7777, 0, 0));
        tab.push_back(mk(0, 0, 0, 1, 16'hFFFF, 16'h9999, 1, 0));
        tab.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h9998, 0, 0));
        tab.push_back(mk(0, 0, 0, 1, 16'h1000, 16'h1000, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0999, 0, 0));
        tab.push_back(mk(0, 0, 0, 1, 16'h0009, 16'h0009, 0, 0));
        tab.push_back(mk(1, 1, 0, 0, 16'h0000, 16'h0010, 0, 0));
        tab.push_back(mk(0, 0, 0, 1, 16'h0999, 16'h0999, 0, 0));
        tab.push_back(mk(1, 1, 0, 0, 16'h0000, 16'h1000, 0, 0));
        tab.push_back(mk(0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h9999, 0, 1));
        tab.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h9998, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h9998, 0, 0));
        tab.push_back(mk(0, 0, 0, 1, 16'hA0B0, 16'h9090, 1, 0));
        tab.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h9090, 0, 0));
        tab.push_back(mk(1, 1, 0, 0, 16'h0000, 16'h9091, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h9090, 0, 0));
        tab.push_back(mk(0, 0, 0, 1, 16'hB000, 16'h9000, 1, 0));
        tab.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0));

        grst = 1'b0; enable = 0; up = 0; clr = 0; load = 0; load_val = '0;
        #3;
        check("reset_count", 32'(count_w), 32'h0);
        check("reset_err", 32'(err_w), 32'h0);
        check("reset_cout", 32'(cout_w), 32'h0);
        @(negedge clk);
        grst = 1'b1;
        mw = 0; ms = 0;

        foreach (tab[i]) apply(tab[i], 1'b1);

        // Saturate: 9998 + 3 up edges holds at 9999, then one down step.
        apply(mk(0, 0, 0, 1, 16'h9998, 16'h0, 0, 0), 1'b0);
        for (int i = 0; i < 3; i++) apply(mk(1, 1, 0, 0, 16'h0, 16'h0, 0, 0), 1'b0);
        check("sat_cout_held", 32'(cout_s), 32'h1);
        apply(mk(1, 0, 0, 0, 16'h0, 16'h0, 0, 0), 1'b0);
        check("sat_down", 32'(count_s), 32'h9998);

        // Full up wrap: cout seen exactly once, at 9999.
        apply(mk(0, 0, 1, 0, 16'h0, 16'h0, 0, 0), 1'b0);
        for (int i = 0; i < 10000; i++) begin
            apply(mk(1, 1, 0, 0, 16'h0, 16'h0, 0, 0), 1'b0);
            if (last_cout_w) cout_hits++;
        end
        check("wrap_cout_once", 32'(cout_hits), 32'd1);
        check("wrap_final", 32'(count_w), 32'h0000);

        // Asynchronous reset mid-count at 0473; pending load discarded.
        apply(mk(0, 0, 0, 1, 16'h0472, 16'h0, 0, 0), 1'b0);
        apply(mk(1, 1, 0, 0, 16'h0, 16'h0, 0, 0), 1'b0);
        @(negedge clk);
        #2 grst = 1'b0;
        #1;
        check("async_rst_count", 32'(count_w), 32'h0);
        check("async_rst_err", 32'(err_w), 32'h0);
        load = 1'b1; load_val = 16'h5555;
        @(posedge clk);
        #1;
        check("rst_load_discard", 32'(count_w), 32'h0);
        @(negedge clk);
        grst = 1'b1; load = 1'b0; enable = 1'b1; up = 1'b1;
        mw = 0; ms = 0;
        #1;
        check("post_rst_cout", 32'(cout_w), 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_first", 32'(count_w), 32'h0001);
        mw = 1; ms = 1;

        // load_err cleared by asynchronous reset.
        apply(mk(0, 0, 0, 1, 16'hAAAA, 16'h0, 0, 0), 1'b0);
        @(negedge clk);
        load = 1'b0; enable = 1'b0;
        #1 grst = 1'b0;
        #1;
        check("async_rst_err_pulse", 32'(err_w), 32'h0);
        check("async_rst_count2", 32'(count_s), 32'h0);
        @(negedge clk);
        grst = 1'b1;
        mw = 0; ms = 0;
        apply(mk(0, 0, 0, 0, 16'h0, 16'h0, 0, 0), 1'b0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_counter_ndigit.md
# bcd_counter_ndigit

Parametrised N-digit packed-BCD counter, the generalised successor to the fixed 4-digit BCD counter. It adds up/down counting, synchronous clear, parallel load with BCD validation, and selectable wrap or saturate at the count limits. It feeds the seven-segment display path directly: one nibble per digit, digit 0 in the least-significant nibble.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal range 1–8.
- `SATURATE`, default 0: 0 wraps at the limits, 1 holds at the limits.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `grst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  count enable.
- `up`  in  1  direction: 1 counts up, 0 counts down; sampled only when counting.
- `clr`  in  1  synchronous clear to zero.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  4*DIGITS  packed-BCD load value.
- `count`  out  4*DIGITS  packed-BCD count, registered.
- `cout`  out  1  terminal-count / carry, combinational from registered state and inputs.
- `load_err`  out  1  registered one-cycle pulse: the last load contained a non-BCD nibble.

## Operation
- **Priority per edge:** `clr` > `load` > `enable` > hold.
- **clr:**
  - `count` becomes 0.
  - `load_err` becomes 0.
- **load:**
  - Each nibble of `load_val` with value 0–9 is copied unchanged.
  - Each nibble with value 10–15 is replaced by 9.
  - `load_err` is 1 on the next cycle if any nibble was replaced, else 0.
- **Count up** (`enable`=1, `up`=1): digit i increments when all lower digits are 9. A digit at 9 that increments becomes 0 and carries.
- **Count down** (`enable`=1, `up`=0): digit i decrements when all lower digits are 0. A digit at 0 that decrements becomes 9 and borrows.
- **Terminal state:** all digits 9 when counting up; all digits 0 when counting down.
- **At the terminal state with `enable`=1 and no `clr` or `load`:**
  - `SATURATE`=0: up wraps to all-0; down wraps to all-9.
  - `SATURATE`=1: `count` holds.
- **`cout`** = `enable` & ~`clr` & ~`load` & (count is at the terminal state for the current `up` value). It is asserted in both modes, and is asserted continuously while saturated and enabled.
- **`load_err`** is cleared on any cycle without `load`. It is a single-cycle pulse.
- **Internal digits:** count is held as DIGITS 4-bit registers that never leave 0–9. There is no binary-to-BCD conversion stage.

## Timing
- **Reset:** `grst`=0 asynchronously forces `count`=0 and `load_err`=0, independent of `clk`. Release is sampled on the next rising edge; the first count happens on the first edge with `grst`=1 and `enable`=1.
- **Reset mid-operation:** `count` returns to 0 immediately. Pending `load` or `clr` is discarded.
- **Latency:** `count` and `load_err` change one cycle after the controlling input is sampled. `cout` is valid in the same cycle as the enabling inputs, with no register stage. This lets cascaded instances use `cout` as the next stage's `enable` with no skew.
- **`cout` after reset:** 0 unless `enable`=1 and `up`=0 (count 0 is the down terminal).
- **Direction change:** a change of `up` takes effect on the very next enabled edge. There is no dead cycle.
- **Simultaneous inputs:**
  - `clr`+`load`+`enable` on one edge yields 0 and `cout`=0.
  - `load`+`enable` yields the loaded value with no count applied.
- **Worst-case combinational path:** the DIGITS-deep carry chain. With DIGITS=8 it must close at the board clock.

## Test plan
- **Reset:** hold `grst`=0 mid-count at 0x0473 → `count`=0x0000 asynchronously, before the next edge, and `load_err`=0. Release `grst`, `enable`=1, `up`=1 → 0x0001 after one edge.
- **Up wrap** (DIGITS=4, SATURATE=0): count up from 0x0000 for 10000 edges → sequence passes through 0x0009→0x0010 and 0x0999→0x1000. `cout`=1 only while `count`=0x9999, then `count`=0x0000.
- **Down wrap:** from 0x0000 with `up`=0 → `cout`=1 in that cycle. Next edge gives 0x9999, then 0x9998; 0x1000 steps to 0x0999.
- **Load validation:** `load_val`=0x12A4 → `count`=0x1294 and a one-cycle `load_err` pulse. `load_val`=0x5678 → `count`=0x5678 and `load_err`=0.
- **Saturate** (SATURATE=1): load 0x9998, count up 3 edges → 0x9999 held. `cout` stays 1 while enabled. Then `up`=0 → 0x9998 on the next edge.
- **Priority:** `count`=0x0042 with `clr`=`load`=`enable`=1 and `load_val`=0x7777 → 0x0000, `cout`=0. Then `load`=`enable`=1 → 0x7777 with no increment.
